// File: rtl/ysyx_22050710_sram_arbiter_if.sv
// Bus bundle between the fetch unit, the load/store unit, the arbiter and the SRAM.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface ysyx_22050710_sram_arbiter_if #(
    parameter int ADDR_WD = 64,
    parameter int DATA_WD = 64
);
    localparam int MW = DATA_WD / 8;

    logic               i_if_req;
    logic [ADDR_WD-1:0] i_if_addr;
    logic               o_if_gnt;
    logic               o_if_rvalid;
    logic [DATA_WD-1:0] o_if_rdata;

    logic               i_ls_req;
    logic               i_ls_wen;
    logic [MW-1:0]      i_ls_wmask;
    logic [ADDR_WD-1:0] i_ls_addr;
    logic [DATA_WD-1:0] i_ls_wdata;
    logic               o_ls_gnt;
    logic               o_ls_rvalid;
    logic [DATA_WD-1:0] o_ls_rdata;

    logic               o_mem_req;
    logic               o_mem_wen;
    logic [MW-1:0]      o_mem_wmask;
    logic [ADDR_WD-1:0] o_mem_addr;
    logic [DATA_WD-1:0] o_mem_wdata;
    logic               i_mem_gnt;
    logic               i_mem_rvalid;
    logic [DATA_WD-1:0] i_mem_rdata;

    logic               o_proto_err;

    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_gnt, o_if_rvalid, o_if_rdata,
        input  i_ls_req, i_ls_wen, i_ls_wmask, i_ls_addr, i_ls_wdata,
        output o_ls_gnt, o_ls_rvalid, o_ls_rdata,
        output o_mem_req, o_mem_wen, o_mem_wmask, o_mem_addr, o_mem_wdata,
        input  i_mem_gnt, i_mem_rvalid, i_mem_rdata,
        output o_proto_err
    );

    modport master (
        output i_if_req, i_if_addr,
        input  o_if_gnt, o_if_rvalid, o_if_rdata,
        output i_ls_req, i_ls_wen, i_ls_wmask, i_ls_addr, i_ls_wdata,
        input  o_ls_gnt, o_ls_rvalid, o_ls_rdata,
        input  o_mem_req, o_mem_wen, o_mem_wmask, o_mem_addr, o_mem_wdata,
        output i_mem_gnt, i_mem_rvalid, i_mem_rdata,
        input  o_proto_err
    );
endinterface

// File: rtl/ysyx_22050710_sram_arbiter.sv
// Two-requester (fetch, load/store) arbiter onto a single SRAM port, one transaction in flight.
// LSU has priority, bounded by a streak counter so a waiting fetch is never starved.
module ysyx_22050710_sram_arbiter #(
    parameter int ADDR_WD       = 64,
    parameter int DATA_WD       = 64,
    parameter int MAX_LS_STREAK = 3
) (
    input logic                         i_clk,
    input logic                         i_rst,
    ysyx_22050710_sram_arbiter_if.slave bus
);
    localparam int MW = DATA_WD / 8;
    localparam int SW = (MAX_LS_STREAK < 1) ? 1 : $clog2(MAX_LS_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
    typedef enum logic {OWN_IF, OWN_LS} owner_e;

    state_e             state_q, state_d;
    owner_e             owner_q, owner_d;
    logic [ADDR_WD-1:0] addr_q, addr_d;
    logic               wen_q, wen_d;
    logic [MW-1:0]      wmask_q, wmask_d;
    logic [DATA_WD-1:0] wdata_q, wdata_d;
    logic [SW-1:0]      streak_q, streak_d;
    logic               proto_err_q, proto_err_d;

    logic ls_win, if_win, ls_gnt, if_gnt, resp_done;

    // A fetch that has watched MAX_LS_STREAK LSU grants in a row takes the next slot.
    assign ls_win    = bus.i_ls_req && !(bus.i_if_req && (streak_q == STREAK_MAX));
    assign if_win    = bus.i_if_req && !ls_win;
    assign ls_gnt    = (state_q == IDLE) && !i_rst && ls_win;
    assign if_gnt    = (state_q == IDLE) && !i_rst && if_win;
    assign resp_done = (state_q == RESP) && bus.i_mem_rvalid;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ls_gnt || if_gnt) state_d = REQ;
            REQ:     if (bus.i_mem_gnt)    state_d = RESP;
            RESP:    if (bus.i_mem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.o_if_gnt    = if_gnt;
        bus.o_ls_gnt    = ls_gnt;
        bus.o_mem_req   = (state_q == REQ) && !i_rst;
        bus.o_if_rvalid = resp_done && !i_rst && (owner_q == OWN_IF);
        bus.o_ls_rvalid = resp_done && !i_rst && (owner_q == OWN_LS);
        bus.o_if_rdata  = bus.i_mem_rdata;
        bus.o_ls_rdata  = bus.i_mem_rdata;
        bus.o_proto_err = proto_err_q;
        bus.o_mem_wen   = 1'b0;
        bus.o_mem_wmask = '0;
        bus.o_mem_addr  = '0;
        bus.o_mem_wdata = '0;
        if (state_q != IDLE) begin
            bus.o_mem_wen   = wen_q;
            bus.o_mem_wmask = wmask_q;
            bus.o_mem_addr  = addr_q;
            bus.o_mem_wdata = wdata_q;
        end
    end

    always_comb begin
        owner_d     = owner_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wmask_d     = wmask_q;
        wdata_d     = wdata_q;
        streak_d    = streak_q;
        proto_err_d = proto_err_q || (bus.i_mem_rvalid && (state_q != RESP));
        if (ls_gnt) begin
            owner_d  = OWN_LS;
            addr_d   = bus.i_ls_addr;
            wen_d    = bus.i_ls_wen;
            wmask_d  = bus.i_ls_wmask;
            wdata_d  = bus.i_ls_wdata;
            if (!bus.i_if_req)              streak_d = '0;
            else if (streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
        end else if (if_gnt) begin
            owner_d  = OWN_IF;
            addr_d   = bus.i_if_addr;
            wen_d    = 1'b0;
            wmask_d  = '0;
            wdata_d  = '0;
            streak_d = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            owner_q     <= OWN_IF;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wmask_q     <= '0;
            wdata_q     <= '0;
            streak_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wmask_q     <= wmask_d;
            wdata_q     <= wdata_d;
            streak_q    <= streak_d;
            proto_err_q <= proto_err_d;
        end
    end
endmodule

// File: tb/tb_ysyx_22050710_sram_arbiter.sv
// Bench for the SRAM arbiter: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a transaction-level model of the arbiter.
module tb_ysyx_22050710_sram_arbiter;
    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int MW   = DW / 8;
    localparam int MAXS = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_22050710_sram_arbiter_if #(.ADDR_WD(AW), .DATA_WD(DW)) bus ();

    ysyx_22050710_sram_arbiter #(
        .ADDR_WD(AW), .DATA_WD(DW), .MAX_LS_STREAK(MAXS)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Abstract model: is a transaction open, has the memory accepted it, and what it carries.
    typedef struct {
        bit          busy;
        bit          issued;
        bit          owner_ls;
        logic [AW-1:0] addr;
        bit          wen;
        logic [MW-1:0] mask;
        logic [DW-1:0] wdata;
        int          streak;
        bit          err;
    } model_t;

    model_t m;
    bit     glog[$];
    int     exp_order [8] = '{1, 1, 1, 0, 1, 1, 1, 0};

    bit            e_ifg, e_lsg, e_req, e_ifv, e_lsv, e_err, e_wen;
    logic [AW-1:0] e_addr;
    logic [MW-1:0] e_mask;
    logic [DW-1:0] e_wdata;
    bit            spurious;

    always @(negedge clk) begin
        if (rst) begin
            {e_ifg, e_lsg, e_req, e_ifv, e_lsv, e_err, e_wen} = '0;
            e_addr = '0; e_mask = '0; e_wdata = '0;
        end else begin
            e_lsg   = !m.busy && bus.i_ls_req && !(bus.i_if_req && m.streak == MAXS);
            e_ifg   = !m.busy && bus.i_if_req && !e_lsg;
            e_req   = m.busy && !m.issued;
            e_ifv   = m.busy && m.issued && bus.i_mem_rvalid && !m.owner_ls;
            e_lsv   = m.busy && m.issued && bus.i_mem_rvalid && m.owner_ls;
            e_err   = m.err;
            e_wen   = m.busy ? m.wen   : 1'b0;
            e_addr  = m.busy ? m.addr  : '0;
            e_mask  = m.busy ? m.mask  : '0;
            e_wdata = m.busy ? m.wdata : '0;
        end
        check("if_gnt",    bus.o_if_gnt,    e_ifg);
        check("ls_gnt",    bus.o_ls_gnt,    e_lsg);
        check("mem_req",   bus.o_mem_req,   e_req);
        check("if_rvalid", bus.o_if_rvalid, e_ifv);
        check("ls_rvalid", bus.o_ls_rvalid, e_lsv);
        check("proto_err", bus.o_proto_err, e_err);
        check("mem_wen",   bus.o_mem_wen,   e_wen);
        check("mem_addr",  bus.o_mem_addr,  e_addr);
        check("mem_wmask", bus.o_mem_wmask, e_mask);
        check("mem_wdata", bus.o_mem_wdata, e_wdata);
        check("if_rdata",  bus.o_if_rdata,  bus.i_mem_rdata);
        check("ls_rdata",  bus.o_ls_rdata,  bus.i_mem_rdata);

        if (bus.o_ls_gnt)      glog.push_back(1'b1);
        else if (bus.o_if_gnt) glog.push_back(1'b0);

        if (rst) begin
            m.busy = 0; m.issued = 0; m.owner_ls = 0; m.addr = '0; m.wen = 0;
            m.mask = '0; m.wdata = '0; m.streak = 0; m.err = 0;
        end else begin
            spurious = bus.i_mem_rvalid && !(m.busy && m.issued);
            if (spurious) m.err = 1;
            if (e_lsg) begin
                m.busy = 1; m.issued = 0; m.owner_ls = 1;
                m.addr = bus.i_ls_addr; m.wen = bus.i_ls_wen;
                m.mask = bus.i_ls_wmask; m.wdata = bus.i_ls_wdata;
                m.streak = bus.i_if_req ? ((m.streak < MAXS) ? m.streak + 1 : MAXS) : 0;
            end else if (e_ifg) begin
                m.busy = 1; m.issued = 0; m.owner_ls = 0;
                m.addr = bus.i_if_addr; m.wen = 0; m.mask = '0; m.wdata = '0;
                m.streak = 0;
            end else if (m.busy && !m.issued && bus.i_mem_gnt) begin
                m.issued = 1;
            end else if (m.busy && m.issued && bus.i_mem_rvalid) begin
                m.busy = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.i_if_req = 0; bus.i_if_addr = '0;
        bus.i_ls_req = 0; bus.i_ls_wen = 0; bus.i_ls_wmask = '0;
        bus.i_ls_addr = '0; bus.i_ls_wdata = '0;
        bus.i_mem_gnt = 0; bus.i_mem_rvalid = 0; bus.i_mem_rdata = '0;
    endtask

    task automatic rand_inputs();
        bus.i_if_req     = ($urandom_range(0, 9) < 6);
        bus.i_if_addr    = {$urandom(), $urandom()};
        bus.i_ls_req     = ($urandom_range(0, 9) < 6);
        bus.i_ls_wen     = $urandom_range(0, 1);
        bus.i_ls_wmask   = MW'($urandom());
        bus.i_ls_addr    = {$urandom(), $urandom()};
        bus.i_ls_wdata   = {$urandom(), $urandom()};
        bus.i_mem_gnt    = $urandom_range(0, 1);
        bus.i_mem_rdata  = {$urandom(), $urandom()};
        bus.i_mem_rvalid = (m.busy && m.issued) ? 1'($urandom_range(0, 1))
                                                : ($urandom_range(0, 199) == 0);
    endtask

    task automatic do_reset();
        tick();
        rst = 1;
        idle_inputs();
        tick();
        rst = 0;
    endtask

    int g0;

    initial begin
        idle_inputs();

        // Reset with both requesters asserted: nothing may be granted.
        tick();
        bus.i_if_req = 1; bus.i_ls_req = 1;
        at_sample();
        check("rst_if_gnt",    bus.o_if_gnt,    0);
        check("rst_ls_gnt",    bus.o_ls_gnt,    0);
        check("rst_mem_req",   bus.o_mem_req,   0);
        check("rst_proto_err", bus.o_proto_err, 0);
        tick();
        rst = 0;
        idle_inputs();

        // Single fetch with minimum turnaround.
        tick();
        bus.i_if_req = 1; bus.i_if_addr = 64'h8000_0000; bus.i_mem_gnt = 1;
        at_sample();
        check("f_if_gnt_c0", bus.o_if_gnt, 1);
        check("f_ls_gnt_c0", bus.o_ls_gnt, 0);
        tick();
        bus.i_if_req = 0;
        at_sample();
        check("f_mem_req_c1",  bus.o_mem_req,  1);
        check("f_mem_addr_c1", bus.o_mem_addr, 64'h8000_0000);
        check("f_mem_wen_c1",  bus.o_mem_wen,  0);
        tick();
        bus.i_mem_rvalid = 1; bus.i_mem_rdata = 64'h13;
        at_sample();
        check("f_if_rvalid_c2", bus.o_if_rvalid, 1);
        check("f_if_rdata_c2",  bus.o_if_rdata,  64'h13);
        check("f_mem_req_c2",   bus.o_mem_req,   0);
        tick();
        idle_inputs();

        // Simultaneous requests with streak 0: LSU first.
        tick();
        bus.i_if_req = 1; bus.i_ls_req = 1; bus.i_ls_addr = 64'h1000; bus.i_mem_gnt = 1;
        at_sample();
        check("s_ls_gnt", bus.o_ls_gnt, 1);
        check("s_if_gnt", bus.o_if_gnt, 0);
        tick();
        at_sample();
        check("s_mem_addr", bus.o_mem_addr, 64'h1000);
        check("s_if_gnt_busy", bus.o_if_gnt, 0);
        tick();
        bus.i_mem_rvalid = 1; bus.i_mem_rdata = 64'hABCD;
        at_sample();
        check("s_ls_rvalid", bus.o_ls_rvalid, 1);
        check("s_if_rvalid", bus.o_if_rvalid, 0);
        tick();
        idle_inputs();
        do_reset();

        // Both held continuously: LS, LS, LS, IF repeating.
        g0 = glog.size();
        for (int i = 0; i < 24; i++) begin
            tick();
            bus.i_if_req = 1; bus.i_ls_req = 1; bus.i_mem_gnt = 1;
            bus.i_ls_addr = {32'h0, $urandom()};
            bus.i_if_addr = {32'h0, $urandom()};
            bus.i_mem_rvalid = m.busy && m.issued;
        end
        tick();
        idle_inputs();
        at_sample();
        check("order_count", 64'(glog.size() - g0), 8);
        for (int i = 0; i < 8; i++)
            if (g0 + i < glog.size())
                check($sformatf("order_%0d", i), 64'(glog[g0 + i]), 64'(exp_order[i]));

        // LSU write stalled by the memory; payload must hold while IF waits.
        tick();
        bus.i_ls_req = 1; bus.i_ls_wen = 1; bus.i_ls_wmask = 8'h0F;
        bus.i_ls_addr = 64'h2000; bus.i_ls_wdata = 64'hDEAD_BEEF;
        at_sample();
        check("w_ls_gnt", bus.o_ls_gnt, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.i_ls_req = 0; bus.i_if_req = 1;
            bus.i_ls_wdata = {$urandom(), $urandom()}; bus.i_ls_wmask = MW'($urandom());
            at_sample();
            check("w_mem_req",   bus.o_mem_req,   1);
            check("w_mem_wdata", bus.o_mem_wdata, 64'hDEAD_BEEF);
            check("w_mem_wmask", bus.o_mem_wmask, 8'h0F);
            check("w_mem_wen",   bus.o_mem_wen,   1);
            check("w_mem_addr",  bus.o_mem_addr,  64'h2000);
            check("w_if_gnt",    bus.o_if_gnt,    0);
        end
        tick();
        bus.i_mem_gnt = 1;
        at_sample();
        check("w_accept_req", bus.o_mem_req, 1);
        tick();
        bus.i_mem_gnt = 0; bus.i_mem_rvalid = 1;
        at_sample();
        check("w_ls_ack", bus.o_ls_rvalid, 1);
        check("w_if_gnt_resp", bus.o_if_gnt, 0);
        tick();
        bus.i_mem_rvalid = 0;
        at_sample();
        check("w_if_gnt_after", bus.o_if_gnt, 1);
        do_reset();

        // Reset in RESP, then a late response.
        tick();
        bus.i_if_req = 1; bus.i_if_addr = 64'h3000; bus.i_mem_gnt = 1;
        tick();
        bus.i_if_req = 0;
        tick();
        rst = 1; bus.i_mem_gnt = 0;
        at_sample();
        check("r_mem_req_rst", bus.o_mem_req,   0);
        check("r_if_rvalid",   bus.o_if_rvalid, 0);
        tick();
        rst = 0; bus.i_mem_rvalid = 1; bus.i_mem_rdata = 64'h55;
        at_sample();
        check("r_late_if_rvalid", bus.o_if_rvalid, 0);
        check("r_late_ls_rvalid", bus.o_ls_rvalid, 0);
        tick();
        bus.i_mem_rvalid = 0; bus.i_if_req = 1; bus.i_if_addr = 64'h4000;
        at_sample();
        check("r_proto_err", bus.o_proto_err, 1);
        check("r_regrant",   bus.o_if_gnt,    1);
        tick();
        bus.i_if_req = 0; bus.i_mem_gnt = 1;
        at_sample();
        check("r_mem_addr", bus.o_mem_addr, 64'h4000);
        tick();
        bus.i_mem_gnt = 0; bus.i_mem_rvalid = 1; bus.i_mem_rdata = 64'h77;
        at_sample();
        check("r_if_rvalid_ok", bus.o_if_rvalid, 1);
        check("r_err_sticky",   bus.o_proto_err, 1);
        tick();
        idle_inputs();
        do_reset();

        // Random traffic with occasional resets and stray responses.
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst = ($urandom_range(0, 149) == 0);
            rand_inputs();
        end
        tick();
        rst = 0;
        idle_inputs();
        tick();
        at_sample();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ysyx_22050710_sram_arbiter.md
YSYX_22050710_SRAM_ARBITER -- requirements
Module: ysyx_22050710_sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WD, default 64, memory address width.
REQ-002 SHALL have parameter DATA_WD, default 64, data width; mask width MW = DATA_WD/8.
REQ-003 SHALL have parameter MAX_LS_STREAK, default 3, consecutive LSU grants allowed while IF waits.
REQ-004 SHALL have one clock and an asynchronous, active-high reset; ports are named i_clk and i_rst.
REQ-005 SHALL have port i_clk, input, 1, clock; all state on rising edge.
REQ-006 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have ports i_if_req (in, 1) and i_if_addr (in, ADDR_WD), fetch read request.
REQ-008 SHALL have ports o_if_gnt (out, 1), o_if_rvalid (out, 1) and o_if_rdata (out, DATA_WD).
REQ-009 SHALL have ports i_ls_req (in, 1), i_ls_wen (in, 1), i_ls_wmask (in, MW), i_ls_addr (in, ADDR_WD) and i_ls_wdata (in, DATA_WD).
REQ-010 SHALL have ports o_ls_gnt (out, 1), o_ls_rvalid (out, 1; read data or write ack) and o_ls_rdata (out, DATA_WD).
REQ-011 SHALL have ports o_mem_req (out, 1), o_mem_wen (out, 1), o_mem_wmask (out, MW), o_mem_addr (out, ADDR_WD) and o_mem_wdata (out, DATA_WD).
REQ-012 SHALL have ports i_mem_gnt (in, 1; request accepted), i_mem_rvalid (in, 1) and i_mem_rdata (in, DATA_WD).
REQ-013 SHALL have port o_proto_err, out, 1, sticky protocol-violation flag.

Function
REQ-014 SHALL implement FSM states IDLE, REQ and RESP, with one transaction outstanding at most.
REQ-015 IDLE SHALL arbitrate combinationally: LSU wins if i_ls_req, unless i_if_req=1 and streak==MAX_LS_STREAK, in which case IF wins.
REQ-016 The winner's gnt SHALL be a single-cycle pulse in IDLE; at most one gnt per cycle; no gnt outside IDLE.
REQ-017 On gnt, the FSM SHALL latch owner, addr, wen, wmask and wdata (IF: wen=0, mask=0) and go to REQ next cycle.
REQ-018 In REQ, o_mem_req=1 with latched payload held stable; on i_mem_gnt=1 go to RESP.
REQ-019 In RESP, o_mem_req=0; on i_mem_rvalid=1, pulse the owner's rvalid in the same cycle (combinational), route i_mem_rdata to that owner's rdata, and go to IDLE.
REQ-020 o_if_rdata/o_ls_rdata SHALL equal i_mem_rdata at all times; only rvalid qualifies them.
REQ-021 Minimum turnaround SHALL be gnt at cycle N, mem accept at N+1, rvalid at N+2, next gnt at N+3.
REQ-022 Streak counter SHALL be 0..MAX_LS_STREAK, saturating: +1 on LSU gnt while i_if_req=1, cleared on IF gnt or on LSU gnt with i_if_req=0.
REQ-023 i_mem_rvalid outside RESP SHALL be ignored for routing and SHALL set o_proto_err.
REQ-024 Requester req deassertion after gnt SHALL NOT affect the in-flight transaction.
REQ-025 Outside IDLE, o_mem_wen/wmask/addr/wdata SHALL show the latched payload; in IDLE they SHALL be 0.

Reset
REQ-026 i_rst SHALL force IDLE, streak=0, latched payload=0, owner=IF and o_proto_err=0 immediately.
REQ-027 During reset, all gnt, rvalid and o_mem_req outputs SHALL be 0.
REQ-028 Reset mid-transaction SHALL abandon it; a late i_mem_rvalid after reset SHALL set o_proto_err and produce no rvalid pulse.

Verification
REQ-029 Only IF req addr 0x80000000, i_mem_gnt=1 immediately, rvalid at next cycle with rdata 0x13 -> o_if_gnt at c0, o_mem_req at c1, o_if_rvalid=1 and o_if_rdata=0x13 at c2.
REQ-030 IF and LSU req same cycle, streak=0 -> o_ls_gnt=1 and o_if_gnt=0; LSU transaction completes first.
REQ-031 IF and LSU held continuously, MAX_LS_STREAK=3 -> grant order LS, LS, LS, IF, LS, LS, LS, IF.
REQ-032 LSU write with wmask 0x0F, wdata 0xDEADBEEF, i_mem_gnt held 0 for 5 cycles -> o_mem_req and payload stable for 5 cycles; ack yields o_ls_rvalid pulse; no IF gnt meanwhile.
REQ-033 i_rst asserted in RESP, then i_mem_rvalid pulse after release -> no rvalid pulse, o_proto_err=1, next request granted normally.
